// File: rtl/decoder_driver.sv
// decoder_driver
//   Accepts a burst request (start address, length, increment mode) through a
//   valid/ready handshake and drives a 2-bit decoder address with a one-cycle
//   enable per beat. A one-cycle done pulse follows the last beat. When
//   GAP_CYCLES > 0, that done cycle is followed by GAP_CYCLES further idle
//   cycles before the next request can be accepted.
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   synchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted this cycle (IDLE and not in reset)
//   req_addr   in   [1:0] starting decoder address
//   req_len    in   [2:0] beats minus one
//   req_incr   in   1 = address +1 per beat (mod 4), 0 = fixed address
//   address0   out  decoder address bit 0 (registered)
//   address1   out  decoder address bit 1 (registered)
//   enable     out  decoder enable, one cycle per beat (registered)
//   busy       out  state is not IDLE
//   done       out  one-cycle pulse after the last beat (registered)
module decoder_driver #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_addr,
  input  logic [2:0] req_len,
  input  logic       req_incr,
  output logic       address0,
  output logic       address1,
  output logic       enable,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] counter;
  logic [2:0] gap_cnt;
  logic [1:0] addr;
  logic       incr_q;
  logic       handshake;

  assign handshake = req_valid && req_ready;
  assign address0  = addr[0];
  assign address1  = addr[1];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (handshake) state_next = BURST;
      BURST:   if (counter == '0) state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (gap_cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Unregistered status outputs; both depend only on the state register
  // (and on reset for req_ready), never on request inputs.
  always_comb begin
    req_ready = (state == IDLE) && !reset;
    busy      = (state != IDLE);
  end

  // Beat counter, address and registered decoder outputs.
  // The GAP counter is loaded with GAP_CYCLES on entry, so the GAP state spans
  // the done cycle plus GAP_CYCLES further cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
      gap_cnt <= '0;
      addr    <= '0;
      incr_q  <= 1'b0;
      enable  <= 1'b0;
      done    <= 1'b0;
    end else begin
      enable <= (state_next == BURST);
      done   <= (state == BURST) && (counter == '0);
      case (state)
        IDLE: begin
          if (handshake) begin
            addr    <= req_addr;
            counter <= req_len;
            incr_q  <= req_incr;
          end
        end
        BURST: begin
          if (counter != '0) begin
            counter <= counter - 3'd1;
            if (incr_q) addr <= addr + 2'd1;
          end else begin
            gap_cnt <= 3'(GAP_CYCLES);
          end
        end
        GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_driver.sv
module tb_decoder_driver;

  typedef struct packed {
    logic       en;
    logic [1:0] a;
    logic       dn;
    logic       bsy;
    logic       rdy;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_addr;
  logic [2:0] req_len;
  logic       req_incr;

  logic rdy_o [2];
  logic a0_o  [2];
  logic a1_o  [2];
  logic en_o  [2];
  logic bsy_o [2];
  logic dn_o  [2];

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Per-DUT expected-cycle schedule, filled at each accepted request.
  exp_t        sched  [2][16];
  int unsigned head   [2];
  int unsigned count  [2];
  exp_t        cur    [2];
  logic [1:0]  last_a [2];

  always #5 clk = ~clk;

  // Instance 0: default gap of one cycle. Instance 1: no gap.
  decoder_driver dut_g1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_o[0]),
    .req_addr(req_addr), .req_len(req_len), .req_incr(req_incr),
    .address0(a0_o[0]), .address1(a1_o[0]), .enable(en_o[0]),
    .busy(bsy_o[0]), .done(dn_o[0])
  );

  decoder_driver #(.GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_o[1]),
    .req_addr(req_addr), .req_len(req_len), .req_incr(req_incr),
    .address0(a0_o[1]), .address1(a1_o[1]), .enable(en_o[1]),
    .busy(bsy_o[1]), .done(dn_o[1])
  );

  function automatic int unsigned gap_of(int unsigned k);
    return (k == 0) ? 1 : 0;
  endfunction

  // Expand one accepted request into its full cycle-by-cycle expectation.
  task automatic build(int unsigned k);
    int unsigned n;
    logic [1:0]  ab;
    n = 0;
    ab = req_addr;
    for (int unsigned b = 0; b <= req_len; b++) begin
      ab = req_incr ? 2'((int'(req_addr) + int'(b)) % 4) : req_addr;
      sched[k][n] = '{en: 1'b1, a: ab, dn: 1'b0, bsy: 1'b1, rdy: 1'b0};
      n++;
    end
    sched[k][n] = '{en: 1'b0, a: ab, dn: 1'b1,
                    bsy: (gap_of(k) > 0), rdy: (gap_of(k) == 0)};
    n++;
    for (int unsigned g = 0; g < gap_of(k); g++) begin
      sched[k][n] = '{en: 1'b0, a: ab, dn: 1'b0, bsy: 1'b1, rdy: 1'b0};
      n++;
    end
    head[k]  = 0;
    count[k] = n;
  endtask

  task automatic check(int unsigned k);
    logic exp_rdy;
    exp_rdy = cur[k].rdy && !reset;
    n_assert++;
    assert (en_o[k] === cur[k].en) else begin
      n_fail++;
      $error("FAIL enable[%0d] observed=%b expected=%b t=%0t", k, en_o[k], cur[k].en, $time);
    end
    n_assert++;
    assert ({a1_o[k], a0_o[k]} === cur[k].a) else begin
      n_fail++;
      $error("FAIL address[%0d] observed=%0d expected=%0d t=%0t", k, {a1_o[k], a0_o[k]}, cur[k].a, $time);
    end
    n_assert++;
    assert (dn_o[k] === cur[k].dn) else begin
      n_fail++;
      $error("FAIL done[%0d] observed=%b expected=%b t=%0t", k, dn_o[k], cur[k].dn, $time);
    end
    n_assert++;
    assert (bsy_o[k] === cur[k].bsy) else begin
      n_fail++;
      $error("FAIL busy[%0d] observed=%b expected=%b t=%0t", k, bsy_o[k], cur[k].bsy, $time);
    end
    n_assert++;
    assert (rdy_o[k] === exp_rdy) else begin
      n_fail++;
      $error("FAIL req_ready[%0d] observed=%b expected=%b t=%0t", k, rdy_o[k], exp_rdy, $time);
    end
  endtask

  // One clock: decide handshakes from pre-edge inputs, advance the model,
  // then compare both DUTs #1 after the edge.
  task automatic step();
    logic hs [2];
    for (int unsigned k = 0; k < 2; k++) hs[k] = req_valid && cur[k].rdy && !reset;
    @(posedge clk);
    #1;
    for (int unsigned k = 0; k < 2; k++) begin
      if (reset) begin
        head[k]   = 0;
        count[k]  = 0;
        last_a[k] = 2'd0;
      end else if (hs[k]) begin
        build(k);
      end
      if (head[k] < count[k]) begin
        cur[k] = sched[k][head[k]];
        head[k]++;
        last_a[k] = cur[k].a;
      end else begin
        cur[k] = '{en: 1'b0, a: last_a[k], dn: 1'b0, bsy: 1'b0, rdy: 1'b1};
      end
      check(k);
    end
  endtask

  task automatic request(input logic [1:0] a, input logic [2:0] l, input logic inc);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    req_incr  = inc;
  endtask

  task automatic idle(input int unsigned n);
    req_valid = 1'b0;
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 2'd0;
    req_len   = 3'd0;
    req_incr  = 1'b0;
    for (int unsigned k = 0; k < 2; k++) begin
      head[k]   = 0;
      count[k]  = 0;
      last_a[k] = 2'd0;
      cur[k]    = '{en: 1'b0, a: 2'd0, dn: 1'b0, bsy: 1'b0, rdy: 1'b0};
    end

    // Reset state
    step();
    step();
    reset = 1'b0;
    idle(2);

    // Single beat at address 2
    request(2'd2, 3'd0, 1'b0);
    step();
    idle(6);

    // Incrementing burst that wraps 3 -> 0
    request(2'd3, 3'd4, 1'b1);
    step();
    idle(9);

    // Eight beats at a fixed address
    request(2'd1, 3'd7, 1'b0);
    step();
    idle(12);

    // Backpressure: valid held, request values changed mid-burst
    request(2'd0, 3'd3, 1'b1);
    step();
    step();
    request(2'd2, 3'd1, 1'b0);
    for (int unsigned i = 0; i < 10; i++) step();
    idle(6);

    // Reset during beat 2 of a six-beat burst
    request(2'd1, 3'd5, 1'b1);
    step();
    idle(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle(4);

    // Back-to-back two-beat requests
    request(2'd3, 3'd1, 1'b1);
    for (int unsigned i = 0; i < 8; i++) step();
    idle(6);

    // Randomized traffic with occasional resets
    for (int unsigned i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 49) == 0);
      req_valid = ($urandom_range(0, 2) != 0);
      req_addr  = 2'($urandom);
      req_len   = 3'($urandom);
      req_incr  = 1'($urandom);
      step();
    end
    reset = 1'b0;
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_driver.md
DECODER_DRIVER -- requirements
Module: decoder_driver

Interface
REQ-001 Parameter GAP_CYCLES, default 1, meaning: idle cycles inserted after each burst before the next request can be accepted (legal range 0..7).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 req_valid  input  1  upstream request present.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_addr  input  2  starting decoder address; bit 0 maps to address0, bit 1 to address1.
REQ-007 req_len  input  3  burst length minus one (0 = 1 beat, 7 = 8 beats).
REQ-008 req_incr  input  1  1 = address increments by one per beat, modulo 4; 0 = address held constant.
REQ-009 address0  output  1  decoder address bit 0.
REQ-010 address1  output  1  decoder address bit 1.
REQ-011 enable  output  1  decoder enable; high for exactly one cycle per beat.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle pulse marking burst completion.

Function
REQ-014 States SHALL be IDLE, BURST and GAP, encoded in a registered state variable.
REQ-015 req_ready SHALL equal 1 exactly when state is IDLE and reset is low; there is no skid buffer.
REQ-016 Handshake SHALL occur on a rising edge where req_valid and req_ready are both 1; req_addr, req_len and req_incr are captured on that edge only.
REQ-017 Inputs while req_ready is 0 SHALL be ignored; req_valid may stay high without effect.
REQ-018 IDLE -> BURST on handshake; otherwise IDLE holds.
REQ-019 In BURST, enable SHALL be 1 every cycle, starting the cycle immediately after the handshake edge (latency 1 cycle).
REQ-020 Beat n (0-based) SHALL present {address1,address0} = req_addr + n mod 4 when req_incr=1, or req_addr when req_incr=0; wrap 3 -> 0 without stall.
REQ-021 BURST SHALL last exactly req_len+1 cycles, tracked by a 3-bit down-counter loaded with req_len.
REQ-022 On the edge ending the last beat, the state SHALL move to GAP if GAP_CYCLES>0, else to IDLE.
REQ-023 done SHALL be 1 for exactly one cycle: the cycle immediately following the last beat, with enable=0 in that cycle.
REQ-024 GAP SHALL last exactly GAP_CYCLES cycles with enable=0 and req_ready=0, then move to IDLE.
REQ-025 With GAP_CYCLES=0, a new handshake may occur on the edge that starts the done cycle's successor; enable SHALL never be high for two bursts without at least one intervening low cycle (the done cycle).
REQ-026 address0/address1 SHALL hold the value of the last beat while enable is 0.
REQ-027 All outputs except req_ready SHALL be registered; no combinational path from request inputs to decoder outputs.

Reset
REQ-028 When reset is sampled high, the next cycle SHALL show state IDLE, enable=0, address0=0, address1=0, busy=0, done=0, counter=0.
REQ-029 Reset SHALL take priority over handshake, beat advance and GAP countdown in the same edge.
REQ-030 Reset mid-BURST or mid-GAP SHALL abort the burst immediately with no done pulse and no further enable beats.
REQ-031 req_ready SHALL be 0 during any cycle reset is high and 1 in the first cycle after reset deasserts.

Verification
REQ-032 Single beat: req_addr=2, req_len=0, req_incr=0, GAP_CYCLES=1 -> enable high one cycle with {a1,a0}=2'b10, done next cycle, req_ready returns 2 cycles after done.
REQ-033 Wrap burst: req_addr=3, req_len=4, req_incr=1 -> five enable cycles with addresses 3,0,1,2,3, then done pulse.
REQ-034 Fixed-address burst: req_addr=1, req_len=7, req_incr=0 -> eight consecutive enable cycles at address 1, busy high for 8+1+GAP_CYCLES cycles.
REQ-035 Backpressure: req_valid held high through a burst with a second request value changed mid-burst -> second request captured only on the first IDLE edge, using values present then.
REQ-036 Reset mid-burst: reset asserted on beat 2 of a len=5 burst -> next cycle enable=0, address=0, done=0, busy=0, req_ready=1 once reset drops.
REQ-037 Back-to-back with GAP_CYCLES=0: two len=1 requests -> enable pattern 1,1,0,1,1 with done in each 0/following slot as per REQ-023.
